lif_neuron_core: RTL and testbench
==================================

// Module: lif_neuron_core
// PURPOSE
//  Leaky integrate-and-fire neuron: integrates a tonic bias plus weighted synaptic events
//  into a membrane potential and fires a one-cycle spike on crossing threshold.
//  After a spike, a refractory period blocks input.
//  Sits directly upstream of the synapse stage: spike drives synapse spike_input.
//  Weighted events from synapse outputs of other neurons close the oscillator loop.
// PARAMETERS
//  V_W        8    membrane width (unsigned potential, 0..2^V_W-1)
//  THRESHOLD  100  fire when next potential >= THRESHOLD
//  LEAK_SHIFT 3    leak term = v >> LEAK_SHIFT; 0 disables leak
//  BIAS       16   unsigned tonic drive added every integrate cycle
//  RESET_POT  0    potential loaded on fire
//  REFRACT    4    refractory length in cycles (0 allowed)
//  CNT_W      16   width of spike_count
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      reset, asynchronous assert, active-low
//  en           in   1      1 = run; 0 = freeze all state, spike forced 0
//  in_valid     in   1      synaptic event present
//  in_weight    in   8      signed synaptic weight (two's complement)
//  in_ready     out  1      event accepted this cycle when in_valid & in_ready
//  spike        out  1      registered one-cycle fire pulse
//  membrane     out  V_W    current potential (registered)
//  refractory   out  1      1 while in REFRACT state
//  spike_count  out  CNT_W  total spikes since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; membrane=0, spike=0, refractory=0, spike_count=0, timer=0. in_ready=0.
//  FSM states: IDLE, INTEGRATE, REFRACT.
//   IDLE -> INTEGRATE on first cycle with en=1 (no integration that cycle).
//   INTEGRATE: in_ready = en. When en=1 at each edge:
//    t = v - (LEAK_SHIFT ? v>>LEAK_SHIFT : 0) + BIAS + (in_valid ? sext(in_weight) : 0).
//    Compute t in V_W+2 signed bits, then clamp to [0, 2^V_W-1].
//    If clamped t >= THRESHOLD:
//     spike<=1, membrane<=RESET_POT, spike_count++.
//     REFRACT=0: stay in INTEGRATE. Otherwise: state<=REFRACT, timer<=REFRACT.
//    Else: membrane<=clamped t, spike<=0.
//   REFRACT: in_ready=0, refractory=1, membrane held, spike<=0 after the fire cycle.
//    timer decrements each en cycle. timer==1 at edge -> INTEGRATE.
//  Latency: event accepted at edge k; resulting spike is visible after edge k.
//   Spike is high for exactly one cycle.
//  With REFRACT=N>0: in_ready is low for exactly N cycles starting the cycle spike is high.
//  in_valid while in_ready=0: not consumed, no effect. Upstream holds the event.
//  en=0 mid-operation: membrane, state and timer frozen. spike<=0. in_ready=0.
//   Resumes exactly where it stopped.
//  rst_n low at any time (incl. mid-REFRACT): immediate return to reset values.
//  Saturation: upper clamp never wraps to small values. Negative weights floor at 0.
//  spike_count wraps 2^CNT_W-1 -> 0 with no flag.
// STRUCTURE
//  Shared package nm_pkg.vh: FSM state encodings (IDLE/INTEGRATE/REFRACT).
//   Also holds the weight width constant W_W=8, shared with synapse and router stages.
//  Sub-module refractory_timer:
//   inputs: load, load value, en. outputs: done, busy.
//   Reused by later synapse-delay stages.
//  Membrane update and clamp are inline combinational logic.
// TESTING
//  1. LEAK_SHIFT=0, BIAS=10, THRESHOLD=100, REFRACT=4, en=1, no events.
//     -> first spike 11 cycles after en rises. Then periodic spikes every 14 cycles.
//  2. BIAS=0, LEAK_SHIFT=0, one event weight=+100.
//     -> spike next cycle, membrane=0, spike_count=1, in_ready low 4 cycles.
//  3. Same config, events weight=+50 held valid through refractory.
//     -> not accepted while in_ready=0. Accepted at 5th cycle after spike. membrane=50.
//  4. BIAS=0, LEAK_SHIFT=0, weight=-128 from membrane=20 -> membrane=0.
//     Then +127 twice with THRESHOLD=255 -> membrane=254, then spike on +127.
//  5. Default params: rst_n pulsed low mid-REFRACT.
//     -> all outputs 0 asynchronously. IDLE until en seen.
//     Next spike timing is identical to a fresh start.
//  6. CNT_W=4, drive 17 spikes -> spike_count=1.
//     en dropped mid-integration 5 cycles -> membrane constant, spike period stretched by 5.

Source files
------------

// File: rtl/nm_pkg.sv
// Shared neuromorphic definitions: FSM state encodings and the synaptic
// weight width used by the neuron, synapse and router stages.
package nm_pkg;

  localparam int W_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTEGRATE = 2'd1,
    ST_REFRACT   = 2'd2
  } nm_state_e;

  // Smallest counter width that can hold a load value of 'len' (at least 1 bit).
  function automatic int timer_width(input int len);
    return (len < 2) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/refractory_timer.sv
// Loadable down-counter with terminal-count detect. 'done' flags the enabled
// cycle on which the count steps from 1 to 0; 'busy' is high while non-zero.
module refractory_timer #(
  parameter int T_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [T_W-1:0] load_val,
  input  logic           en,
  output logic           done,
  output logic           busy
);

  logic [T_W-1:0] cnt;

  // Load takes priority; otherwise count down while enabled and not yet empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - T_W'(1);
    end
  end

  assign done = en && (cnt == T_W'(1));
  assign busy = (cnt != '0);

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron. Integrates tonic bias plus weighted
// synaptic events into a clamped membrane potential, emits a one-cycle spike
// on reaching threshold, then blocks input for a refractory period.
//
//  state        | meaning
//  -------------+-------------------------------------------------------
//  ST_IDLE      | after reset, waiting for the first enabled cycle
//  ST_INTEGRATE | leak + bias + event accumulated every enabled cycle
//  ST_REFRACT   | post-spike hold, inputs refused until the timer expires
module lif_neuron_core
  import nm_pkg::*;
#(
  parameter int V_W        = 8,
  parameter int THRESHOLD  = 100,
  parameter int LEAK_SHIFT = 3,
  parameter int BIAS       = 16,
  parameter int RESET_POT  = 0,
  parameter int REFRACT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [W_W-1:0]   in_weight,
  output logic             in_ready,
  output logic             spike,
  output logic [V_W-1:0]   membrane,
  output logic             refractory,
  output logic [CNT_W-1:0] spike_count
);

  // Two guard bits: one for the sign of a negative sum, one for overflow.
  localparam int S_W = V_W + 2;
  localparam int T_W = timer_width(REFRACT);

  nm_state_e        state, state_nxt;
  logic [V_W-1:0]   membrane_nxt;
  logic             spike_nxt;
  logic [CNT_W-1:0] count_nxt;

  logic signed [S_W-1:0] v_ext, leak_ext, bias_ext, w_ext, t_sum;
  logic [V_W-1:0]        v_clamp;
  logic                  fire;

  logic tmr_load, tmr_en, tmr_done, tmr_busy;

  // Candidate potential for this cycle, saturated into the unsigned range.
  always_comb begin
    v_ext    = {2'b00, membrane};
    leak_ext = '0;
    if (LEAK_SHIFT != 0) leak_ext = {2'b00, membrane >> LEAK_SHIFT};
    bias_ext = S_W'(BIAS);
    w_ext    = '0;
    if (in_valid) w_ext = {{(S_W - W_W){in_weight[W_W-1]}}, in_weight};
    t_sum = v_ext - leak_ext + bias_ext + w_ext;
    if (t_sum[S_W-1]) begin
      v_clamp = '0;
    end else if (t_sum[V_W]) begin
      v_clamp = '1;
    end else begin
      v_clamp = t_sum[V_W-1:0];
    end
  end

  assign fire = (v_clamp >= V_W'(THRESHOLD));

  // Next-state and datapath decisions; en low freezes everything but spike.
  always_comb begin
    state_nxt    = state;
    membrane_nxt = membrane;
    spike_nxt    = 1'b0;
    count_nxt    = spike_count;
    tmr_load     = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_INTEGRATE;
        end
        ST_INTEGRATE: begin
          if (fire) begin
            spike_nxt    = 1'b1;
            membrane_nxt = V_W'(RESET_POT);
            count_nxt    = spike_count + CNT_W'(1);
            if (REFRACT != 0) begin
              state_nxt = ST_REFRACT;
              tmr_load  = 1'b1;
            end
          end else begin
            membrane_nxt = v_clamp;
          end
        end
        ST_REFRACT: begin
          // An empty timer here can only mean a corrupted count; leave rather than hang.
          if (tmr_done || !tmr_busy) state_nxt = ST_INTEGRATE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      membrane    <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state       <= state_nxt;
      membrane    <= membrane_nxt;
      spike       <= spike_nxt;
      spike_count <= count_nxt;
    end
  end

  assign tmr_en = en && (state == ST_REFRACT);

  refractory_timer #(
    .T_W (T_W)
  ) u_refractory_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (T_W'(REFRACT)),
    .en       (tmr_en),
    .done     (tmr_done),
    .busy     (tmr_busy)
  );

  assign in_ready   = en && (state == ST_INTEGRATE);
  assign refractory = (state == ST_REFRACT);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core using four differently parameterised
// instances that share clock and reset.
module tb_lif_neuron_core;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // A: no leak, bias 10, 4-bit spike counter
  logic       en_a, vld_a, rdy_a, spk_a, ref_a;
  logic [7:0] wt_a, mem_a;
  logic [3:0] cnt_a;
  // B: no leak, no bias, threshold 100
  logic        en_b, vld_b, rdy_b, spk_b, ref_b;
  logic [7:0]  wt_b, mem_b;
  logic [15:0] cnt_b;
  // C: no leak, no bias, threshold 255
  logic        en_c, vld_c, rdy_c, spk_c, ref_c;
  logic [7:0]  wt_c, mem_c;
  logic [15:0] cnt_c;
  // D: default parameters
  logic        en_d, vld_d, rdy_d, spk_d, ref_d;
  logic [7:0]  wt_d, mem_d;
  logic [15:0] cnt_d;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_d [10] = '{16, 30, 43, 54, 64, 72, 79, 86, 92, 97};

  lif_neuron_core #(.V_W(8), .THRESHOLD(100), .LEAK_SHIFT(0), .BIAS(10),
                    .RESET_POT(0), .REFRACT(4), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(vld_a), .in_weight(wt_a),
    .in_ready(rdy_a), .spike(spk_a), .membrane(mem_a), .refractory(ref_a),
    .spike_count(cnt_a));

  lif_neuron_core #(.V_W(8), .THRESHOLD(100), .LEAK_SHIFT(0), .BIAS(0),
                    .RESET_POT(0), .REFRACT(4), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(vld_b), .in_weight(wt_b),
    .in_ready(rdy_b), .spike(spk_b), .membrane(mem_b), .refractory(ref_b),
    .spike_count(cnt_b));

  lif_neuron_core #(.V_W(8), .THRESHOLD(255), .LEAK_SHIFT(0), .BIAS(0),
                    .RESET_POT(0), .REFRACT(4), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .in_valid(vld_c), .in_weight(wt_c),
    .in_ready(rdy_c), .spike(spk_c), .membrane(mem_c), .refractory(ref_c),
    .spike_count(cnt_c));

  lif_neuron_core u_d (
    .clk(clk), .rst_n(rst_n), .en(en_d), .in_valid(vld_d), .in_weight(wt_d),
    .in_ready(rdy_d), .spike(spk_d), .membrane(mem_d), .refractory(ref_d),
    .spike_count(cnt_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One full firing period on instance A ending with the next spike.
  task automatic period_a(input int gap);
    for (int i = 1; i < gap; i++) begin
      tick();
      check("a_per_spk", spk_a, 0);
      check("a_per_rdy", rdy_a, (i >= 4));
      check("a_per_ref", ref_a, (i < 4));
    end
    tick();
    check("a_per_fire", spk_a, 1);
    check("a_per_mem", mem_a, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 0; vld_a = 0; wt_a = 0;
    en_b = 0; vld_b = 0; wt_b = 0;
    en_c = 0; vld_c = 0; wt_c = 0;
    en_d = 0; vld_d = 0; wt_d = 0;
    #1;
    check("rst_spk_a", spk_a, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_rdy_a", rdy_a, 0);
    check("rst_ref_a", ref_a, 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_cnt_d", cnt_d, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_rdy_a", rdy_a, 0);

    // Bias-only integration, fire and periodic firing
    en_a = 1;
    tick();
    check("t1_start_mem", mem_a, 0);
    check("t1_start_rdy", rdy_a, 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("t1_mem", mem_a, 10 * k);
      check("t1_spk", spk_a, 0);
    end
    tick();
    check("t1_fire", spk_a, 1);
    check("t1_fire_mem", mem_a, 0);
    check("t1_fire_cnt", cnt_a, 1);
    check("t1_fire_ref", ref_a, 1);
    check("t1_fire_rdy", rdy_a, 0);
    period_a(14);
    check("t1_cnt2", cnt_a, 2);

    // en dropped for 5 cycles mid-integration stretches the period to 19
    repeat (8) tick();
    check("t6_mem_pre", mem_a, 40);
    en_a = 0;
    #1;
    check("t6_rdy_off", rdy_a, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_frozen_mem", mem_a, 40);
      check("t6_frozen_spk", spk_a, 0);
      check("t6_frozen_rdy", rdy_a, 0);
    end
    en_a = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t6_resume_mem", mem_a, 40 + 10 * k);
      check("t6_resume_spk", spk_a, 0);
    end
    tick();
    check("t6_fire", spk_a, 1);
    check("t6_cnt3", cnt_a, 3);
    for (int n = 4; n <= 17; n++) begin
      period_a(14);
      if (n == 16) check("t6_cnt_wrap", cnt_a, 0);
    end
    check("t6_cnt17", cnt_a, 1);
    en_a = 0;

    // Single large event fires, then a held event waits out refractory
    en_b = 1;
    tick();
    check("t2_start_mem", mem_b, 0);
    check("t2_start_rdy", rdy_b, 1);
    vld_b = 1; wt_b = 8'd100;
    tick();
    check("t2_fire", spk_b, 1);
    check("t2_mem", mem_b, 0);
    check("t2_cnt", cnt_b, 1);
    check("t2_rdy", rdy_b, 0);
    check("t2_ref", ref_b, 1);
    wt_b = 8'd50;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t3_block_rdy", rdy_b, 0);
      check("t3_block_mem", mem_b, 0);
      check("t3_block_spk", spk_b, 0);
    end
    tick();
    check("t3_ready_back", rdy_b, 1);
    check("t3_not_yet", mem_b, 0);
    tick();
    check("t3_accept_mem", mem_b, 50);
    check("t3_accept_spk", spk_b, 0);
    check("t3_cnt", cnt_b, 1);
    vld_b = 0;
    tick();
    check("t3_hold_mem", mem_b, 50);
    en_b = 0;

    // Floor at zero, saturation near the top, fire at full scale
    en_c = 1;
    tick();
    vld_c = 1; wt_c = 8'd20;
    tick();
    check("t4_mem20", mem_c, 20);
    wt_c = 8'h80;
    tick();
    check("t4_floor", mem_c, 0);
    wt_c = 8'd127;
    tick();
    check("t4_mem127", mem_c, 127);
    tick();
    check("t4_mem254", mem_c, 254);
    check("t4_nospk", spk_c, 0);
    tick();
    check("t4_sat_fire", spk_c, 1);
    check("t4_sat_mem", mem_c, 0);
    check("t4_sat_cnt", cnt_c, 1);
    vld_c = 0;
    en_c = 0;

    // Default leaky neuron, then async reset mid-refractory and a replay
    en_d = 1;
    tick();
    check("t5_start_mem", mem_d, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_leak_mem", mem_d, exp_d[k]);
      check("t5_leak_spk", spk_d, 0);
    end
    tick();
    check("t5_fire", spk_d, 1);
    check("t5_fire_cnt", cnt_d, 1);
    repeat (2) tick();
    check("t5_mid_ref", ref_d, 1);
    check("t5_mid_rdy", rdy_d, 0);
    #2 rst_n = 1'b0;
    en_d = 0;
    #1;
    check("t5_async_ref", ref_d, 0);
    check("t5_async_cnt", cnt_d, 0);
    check("t5_async_mem", mem_d, 0);
    check("t5_async_spk", spk_d, 0);
    check("t5_async_rdy", rdy_d, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("t5_idle_mem", mem_d, 0);
      check("t5_idle_ref", ref_d, 0);
      check("t5_idle_rdy", rdy_d, 0);
    end
    en_d = 1;
    tick();
    check("t5_re_start", rdy_d, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_re_mem", mem_d, exp_d[k]);
      check("t5_re_spk", spk_d, 0);
    end
    tick();
    check("t5_re_fire", spk_d, 1);
    check("t5_re_cnt", cnt_d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
